// File: rtl/inst_fetcher.sv
// Instruction fetcher: assembles 32-bit words from a byte-serial little-endian memory
// port and pushes them to the issue queue. Optional instruction cache: define ICACHE_EN.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ICACHE_LINES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        issue_need_inst_in,
  output logic [31:0] inst_out,
  output logic        inst_ready_out,
  output logic [31:0] inst_addr_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic [7:0]  mem_data_in,
  input  logic        mem_data_valid_in
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, WAIT_JALR} state_t;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two, at least 2");
  end

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buffer;
  logic [2:0]  cnt;        // bytes received
  logic [2:0]  ridx;       // byte index of the request currently on the bus
  logic        push_q;
  logic        req_q;      // request seen by memory last cycle, and its address
  logic [31:0] addr_q;

  logic [31:0] byte_addr;
  logic [31:0] imm_j;
  logic [31:0] next_pc;
  logic        acc;
  logic        lost;
  logic [2:0]  cnt_n;
  logic [2:0]  nidx;
  logic        hit;
  logic [31:0] hit_data;

  assign imm_j          = {{12{buffer[31]}}, buffer[19:12], buffer[20], buffer[30:21], 1'b0};
  assign inst_ready_out = push_q & rdy_in;

  // A returned byte is taken only if it answers the address of the byte we need next;
  // an unanswered request rewinds the request stream to the first missing byte.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    byte_addr = pc + {29'd0, cnt};
    acc       = (state == FETCH) && mem_data_valid_in && req_q && (addr_q == byte_addr);
    lost      = req_q && !acc;
    cnt_n     = cnt + {2'd0, acc};
    nidx      = ridx;
    if (lost) begin
      nidx = (mem_req_out && (ridx == cnt_n)) ? ridx + 3'd1 : cnt_n;
    end else if (mem_req_out) begin
      nidx = ridx + 3'd1;
    end
    next_pc = pc + 32'd4;
    if (buffer[6:0] == OP_JAL) next_pc = pc + imm_j;
  end

`ifdef ICACHE_EN
  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [31:0]       line_data [ICACHE_LINES];
  logic [TAG_W-1:0]  line_tag  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] line_valid;
  logic [IDX_W-1:0]  idx;
  logic              fill;

  assign idx      = pc[IDX_W+1:2];
  assign hit      = line_valid[idx] && (line_tag[idx] == pc[31:IDX_W+2]);
  assign hit_data = line_data[idx];
  assign fill     = rdy_in && !clear_in && acc && (cnt == 3'd3);

  // NOTE: cache storage has no reset; only the valid bits need a known state.
  always_ff @(posedge clk_in) begin
    if (fill) begin
      line_data[idx] <= {mem_data_in, buffer[23:0]};
      line_tag[idx]  <= pc[31:IDX_W+2];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in)   line_valid      <= '0;
    else if (fill) line_valid[idx] <= 1'b1;
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 32'd0;
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      buffer        <= 32'd0;
      cnt           <= 3'd0;
      ridx          <= 3'd0;
      push_q        <= 1'b0;
      req_q         <= 1'b0;
      addr_q        <= 32'd0;
      inst_out      <= 32'd0;
      inst_addr_out <= 32'd0;
      mem_req_out   <= 1'b0;
      mem_addr_out  <= 32'd0;
    end else begin
      // The bus tracker follows the memory port even while frozen, so answers that
      // arrive after a freeze are matched against what memory actually saw.
      req_q  <= mem_req_out && !(rdy_in && clear_in);
      addr_q <= mem_addr_out;
      if (rdy_in) begin
        push_q <= 1'b0;
        if (clear_in) begin
          state       <= IDLE;
          pc          <= redirect_pc_in;
          cnt         <= 3'd0;
          ridx        <= 3'd0;
          buffer      <= 32'd0;
          mem_req_out <= 1'b0;
        end else begin
          unique case (state)
            IDLE: begin
              if (issue_need_inst_in) begin
                if (hit) begin
                  buffer <= hit_data;
                  state  <= SEND;
                end else begin
                  state        <= FETCH;
                  mem_req_out  <= 1'b1;
                  mem_addr_out <= pc;
                  cnt          <= 3'd0;
                  ridx         <= 3'd0;
                end
              end
            end
            FETCH: begin
              if (acc) begin
                buffer[8*cnt[1:0] +: 8] <= mem_data_in;
                cnt                     <= cnt_n;
              end
              if (acc && (cnt == 3'd3)) begin
                state       <= SEND;
                mem_req_out <= 1'b0;
              end else if (nidx <= 3'd3) begin
                mem_req_out  <= 1'b1;
                mem_addr_out <= pc + {29'd0, nidx};
                ridx         <= nidx;
              end else begin
                mem_req_out <= 1'b0;
                ridx        <= nidx;
              end
            end
            SEND: begin
              if (issue_need_inst_in) begin
                push_q        <= 1'b1;
                inst_out      <= buffer;
                inst_addr_out <= pc;
                if (buffer[6:0] == OP_JALR) begin
                  state <= WAIT_JALR;
                end else begin
                  pc    <= next_pc;
                  state <= IDLE;
                end
              end
            end
            WAIT_JALR: begin
              mem_req_out <= 1'b0;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: byte-serial memory model, push scoreboard,
// table of next-PC vectors and hand-written JALR / backpressure / clear / freeze sequences.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic [31:0] redirect_pc_in;
  logic        issue_need_inst_in;
  logic [31:0] inst_out;
  logic        inst_ready_out;
  logic [31:0] inst_addr_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic [7:0]  mem_data_in = 8'd0;
  logic        mem_data_valid_in = 1'b0;

  always #5 clk_in = ~clk_in;

  inst_fetcher #(.RESET_PC(32'h0000_0000), .ICACHE_LINES(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .redirect_pc_in(redirect_pc_in), .issue_need_inst_in(issue_need_inst_in),
    .inst_out(inst_out), .inst_ready_out(inst_ready_out), .inst_addr_out(inst_addr_out),
    .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
    .mem_data_in(mem_data_in), .mem_data_valid_in(mem_data_valid_in)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } push_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] next_pc;
  } vec_t;

  push_t       sb[$];
  int          checks = 0;
  int          passed = 0;
  int          push_count = 0;
  int          cyc = 0;
  int          last_push_cyc = 0;
  int          prev_push_cyc = 0;
  logic        stall_mem = 1'b0;
  logic [31:0] words [logic [29:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = words.exists(a[31:2]) ? words[a[31:2]] : 32'h0000_0013;
    return w[8*a[1:0] +: 8];
  endfunction

  // Memory answers the request it saw at a clock edge during the following cycle.
  logic        mem_r;
  logic [31:0] mem_a;
  always @(posedge clk_in) begin
    cyc++;
    mem_r = mem_req_out && !stall_mem;
    mem_a = mem_addr_out;
    #1;
    mem_data_valid_in = mem_r;
    mem_data_in       = mem_byte(mem_a);
  end

  always @(negedge clk_in) begin
    if (inst_ready_out) begin
      push_t e;
      push_count++;
      prev_push_cyc = last_push_cyc;
      last_push_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_push: got inst %h at %h, expected no push", inst_out, inst_addr_out);
      end else begin
        e = sb.pop_front();
        check("push_inst", inst_out, e.inst);
        check("push_addr", inst_addr_out, e.addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_clear(input logic [31:0] pc);
    clear_in       = 1'b1;
    redirect_pc_in = pc;
    tick();
    clear_in = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk_in);
      #1;
    end
    checks++;
    $display("FAIL %s: got %0d pushes still pending, expected 0", name, sb.size());
    sb.delete();
  endtask

  task automatic wait_fetch(input string name, output logic [31:0] a);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      #1;
      if (mem_req_out) begin
        a = mem_addr_out;
        return;
      end
    end
    a = 32'hFFFF_FFFF;
    checks++;
    $display("FAIL %s: got no mem_req_out within 60 cycles, expected a fetch", name);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs [7];
    logic [31:0] a;
    logic [31:0] addrs[$];
    int          base;
    int          cnt;

    vecs[0] = '{32'h0000_0040, 32'h0050_0093, 32'h0000_0044};  // addi
    vecs[1] = '{32'h0000_0008, 32'h0100_006F, 32'h0000_0018};  // jal +16
    vecs[2] = '{32'h0000_0020, 32'hFF9F_F06F, 32'h0000_0018};  // jal -8
    vecs[3] = '{32'hFFFF_FFFC, 32'h00A0_0113, 32'h0000_0000};  // wrap to 0
    vecs[4] = '{32'h0000_0080, 32'h0000_0063, 32'h0000_0084};  // beq, not taken
    vecs[5] = '{32'h0000_0104, 32'h7FFF_F06F, 32'h0010_0102};  // jal max positive
    vecs[6] = '{32'hFFFF_FFF0, 32'h0200_006F, 32'h0000_0010};  // jal wrapping

    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; redirect_pc_in = 32'd0;
    issue_need_inst_in = 1'b0;
    words[30'd0] = 32'h0050_0093;
    repeat (3) tick();
    @(negedge clk_in);
    check("rst_inst_out", inst_out, 32'd0);
    check("rst_inst_addr", inst_addr_out, 32'd0);
    check("rst_inst_ready", {31'd0, inst_ready_out}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req_out}, 32'd0);
    check("rst_mem_addr", mem_addr_out, 32'd0);

    // First fetch from reset: byte addresses 0..3, one push, next fetch at 4.
    sb.push_back('{32'h0050_0093, 32'h0});
    tick();
    rst_in = 1'b1;
    issue_need_inst_in = 1'b1;
    for (int i = 0; i < 40 && push_count == 0; i++) begin
      @(negedge clk_in);
      #1;
      if (mem_req_out) addrs.push_back(mem_addr_out);
    end
    check("first_req_count", addrs.size(), 4);
    for (int i = 0; i < addrs.size() && i < 4; i++) check($sformatf("first_req_addr%0d", i), addrs[i], i);
    wait_drained("first_push");
    wait_fetch("first_next", a);
    check("first_next_pc", a, 32'h4);

    for (int i = 0; i < 7; i++) begin
      words[vecs[i].pc[31:2]] = vecs[i].inst;
      sb.push_back('{vecs[i].inst, vecs[i].pc});
      do_clear(vecs[i].pc);
      wait_drained($sformatf("vec%0d_push", i));
      wait_fetch($sformatf("vec%0d_next", i), a);
      check($sformatf("vec%0d_next_pc", i), a, vecs[i].next_pc);
    end

    // JALR: pushed, then fetch stays quiet until a redirect.
    words[30'd3] = 32'h0000_80E7;
    sb.push_back('{32'h0000_80E7, 32'hC});
    do_clear(32'hC);
    wait_drained("jalr_push");
    base = push_count;
    cnt  = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (mem_req_out) cnt++;
    end
    check("jalr_no_req", cnt, 0);
    check("jalr_no_push", push_count - base, 0);
    #1;
    do_clear(32'h100);
    wait_fetch("jalr_redirect", a);
    check("jalr_redirect_pc", a, 32'h100);

    // Backpressure: word waits in SEND, then exactly one push.
    words[30'h14] = 32'h02A0_0293;
    do_clear(32'h50);
    wait_fetch("bp_fetch", a);
    check("bp_fetch_pc", a, 32'h50);
    issue_need_inst_in = 1'b0;
    base = push_count;
    repeat (16) tick();
    check("bp_no_push", push_count - base, 0);
    sb.push_back('{32'h02A0_0293, 32'h50});
    issue_need_inst_in = 1'b1;
    repeat (4) tick();
    issue_need_inst_in = 1'b0;
    repeat (12) tick();
    check("bp_one_push", push_count - base, 1);
    check("bp_sb_empty", sb.size(), 0);

    // Clear mid-fetch at 40 (also lands on a pending SEND of 0x54): partial word dropped.
    words[30'd10] = 32'h0030_0193;
    words[30'd50] = 32'h0040_0213;
    issue_need_inst_in = 1'b1;
    do_clear(32'd40);
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 2; i++) begin
      @(negedge clk_in);
      #1;
      if (mem_data_valid_in) cnt++;
    end
    check("partial_beats", cnt, 2);
    sb.push_back('{32'h0040_0213, 32'd200});
    do_clear(32'd200);
    @(negedge clk_in);
    check("clear_req_low", {31'd0, mem_req_out}, 32'd0);
    check("clear_push_low", {31'd0, inst_ready_out}, 32'd0);
    wait_fetch("partial_refetch", a);
    check("partial_refetch_pc", a, 32'd200);
    wait_drained("partial_push");

    // rdy_in low for 5 cycles mid-fetch: request frozen, word still assembled correctly.
    words[30'h18] = 32'h1234_5678;
    sb.push_back('{32'h1234_5678, 32'h60});
    do_clear(32'h60);
    for (int i = 0; i < 40 && !mem_data_valid_in; i++) begin
      @(negedge clk_in);
      #1;
    end
    check("freeze_pre_addr", mem_addr_out, 32'h61);
    tick();
    rdy_in = 1'b0;
    repeat (5) begin
      @(negedge clk_in);
      check("freeze_addr", mem_addr_out, 32'h62);
      check("freeze_req", {31'd0, mem_req_out}, 32'd1);
      check("freeze_push", {31'd0, inst_ready_out}, 32'd0);
    end
    #1;
    rdy_in = 1'b1;
    wait_drained("freeze_push");
    wait_fetch("freeze_next", a);
    check("freeze_next_pc", a, 32'h64);

    // Memory stalls mid-fetch stretch the fetch without corrupting it.
    words[30'h1C] = 32'hDEAD_BEB3;
    sb.push_back('{32'hDEAD_BEB3, 32'h70});
    do_clear(32'h70);
    for (int i = 0; i < 40 && !mem_data_valid_in; i++) begin
      @(negedge clk_in);
      #1;
    end
    stall_mem = 1'b1;
    repeat (3) tick();
    stall_mem = 1'b0;
    wait_drained("stall_push");
    wait_fetch("stall_next", a);
    check("stall_next_pc", a, 32'h74);

`ifdef ICACHE_EN
    // JAL-to-self loop: the second visit hits and pushes without memory traffic.
    words[30'hC0] = 32'h0000_006F;
    sb.push_back('{32'h0000_006F, 32'h300});
    sb.push_back('{32'h0000_006F, 32'h300});
    do_clear(32'h300);
    for (int i = 0; i < 60 && sb.size() > 1; i++) begin
      @(negedge clk_in);
      #1;
    end
    cnt = 0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge clk_in);
      #1;
      if (mem_req_out) cnt++;
    end
    issue_need_inst_in = 1'b0;
    check("cache_no_req", cnt, 0);
    check("cache_sb_empty", sb.size(), 0);
    check("cache_push_gap", last_push_cyc - prev_push_cyc, 2);
    repeat (5) tick();
`endif

    issue_need_inst_in = 1'b0;
    do_clear(32'h400);
    repeat (5) tick();
    check("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
